// File: rtl/latch_q_capture_if.sv
// ----------------------------------------------------------------------------
// latch_q_capture_if
// Bundles the signals between the latch-side producer / word consumer and
// latch_q_capture.
//   q_in, q_bar_in  : complementary latch outputs, asynchronous to clk
//   sample          : one-cycle strobe, capture the synced q as the next bit
//   data_ready      : consumer accepts data_out while data_valid is high
//   data_out        : assembled word, MSB = first bit sampled
//   data_valid      : word complete and held
//   bit_cnt         : bits collected in the current word
//   err_invalid     : sticky, q == q_bar persisted ERR_CYCLES cycles
//   overrun         : sticky, sample arrived while a word was held
// master = environment side (drives stimulus), slave = capture block.
// ----------------------------------------------------------------------------
interface latch_q_capture_if #(
   parameter int unsigned WIDTH = 8
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   logic             q_in;
   logic             q_bar_in;
   logic             sample;
   logic             data_ready;
   logic [WIDTH-1:0] data_out;
   logic             data_valid;
   logic [CNT_W-1:0] bit_cnt;
   logic             err_invalid;
   logic             overrun;

   modport master (
      output q_in,
      output q_bar_in,
      output sample,
      output data_ready,
      input  data_out,
      input  data_valid,
      input  bit_cnt,
      input  err_invalid,
      input  overrun
   );

   modport slave (
      input  q_in,
      input  q_bar_in,
      input  sample,
      input  data_ready,
      output data_out,
      output data_valid,
      output bit_cnt,
      output err_invalid,
      output overrun
   );
endinterface

// File: rtl/latch_q_capture.sv
// ----------------------------------------------------------------------------
// latch_q_capture
// Consumes the gated D latch's complementary outputs: synchronises q/q_bar
// into clk, watches that they stay complementary, shifts a validated q bit in
// on each sample strobe and offers each completed WIDTH-bit word over a
// valid/ready handshake.
// Ports:
//   clk  : rising-edge clock, sole clock
//   rst  : synchronous active-high reset
//   bus  : latch_q_capture_if.slave (latch inputs, strobe, word handshake,
//          status flags); all outputs are registered.
// ----------------------------------------------------------------------------
module latch_q_capture #(
   parameter int unsigned WIDTH       = 8,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned ERR_CYCLES  = 4
) (
   input  logic                clk,
   input  logic                rst,
   latch_q_capture_if.slave    bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH + 1);
   localparam int unsigned INV_W = $clog2(ERR_CYCLES + 1);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [INV_W-1:0] INV_MAX  = INV_W'(ERR_CYCLES);

   // COLLECT: shifting bits in; FULL: last bit just landed, raise valid next;
   // HOLD: word presented until the consumer takes it.
   typedef enum logic [1:0] {
      S_COLLECT = 2'd0,
      S_FULL    = 2'd1,
      S_HOLD    = 2'd2
   } state_e;

   state_e           state_q,     state_d;
   logic [SYNC_STAGES-1:0] q_sync_q,  q_sync_d;
   logic [SYNC_STAGES-1:0] qb_sync_q, qb_sync_d;
   logic [INV_W-1:0] inv_cnt_q,   inv_cnt_d;
   logic             err_q,       err_d;
   logic             overrun_q,   overrun_d;
   logic [WIDTH-1:0] data_q,      data_d;
   logic             valid_q,     valid_d;
   logic [CNT_W-1:0] bit_cnt_q,   bit_cnt_d;

   logic qs;
   logic qbs;
   logic pair_ok;
   logic take_bit;

   // Synchronised latch outputs and per-cycle complementarity.
   assign qs       = q_sync_q[SYNC_STAGES-1];
   assign qbs      = qb_sync_q[SYNC_STAGES-1];
   assign pair_ok  = qs ^ qbs;
   assign take_bit = bus.sample & pair_ok;

   // Synchroniser shift and invalid-pair run-length tracking.
   always_comb begin
      q_sync_d  = {q_sync_q[SYNC_STAGES-2:0],  bus.q_in};
      qb_sync_d = {qb_sync_q[SYNC_STAGES-2:0], bus.q_bar_in};
      inv_cnt_d = inv_cnt_q;
      if (pair_ok) begin
         inv_cnt_d = '0;
      end else if (inv_cnt_q != INV_MAX) begin
         inv_cnt_d = inv_cnt_q + INV_W'(1);
      end
      // Flag lands the cycle after the run reaches its limit, then sticks.
      err_d = err_q | (inv_cnt_q == INV_MAX);
   end

   // Word assembly FSM: next state and next register values.
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      valid_d   = valid_q;
      bit_cnt_d = bit_cnt_q;
      overrun_d = overrun_q;

      case (state_q)
         S_COLLECT: begin
            if (take_bit) begin
               data_d    = {data_q[WIDTH-2:0], qs};
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
               if (bit_cnt_q == CNT_LAST) begin
                  state_d = S_FULL;
               end
            end
         end

         S_FULL: begin
            // Word is complete but not yet offered; any strobe here is lost.
            valid_d = 1'b1;
            state_d = S_HOLD;
            if (bus.sample) begin
               overrun_d = 1'b1;
            end
         end

         S_HOLD: begin
            if (valid_q && bus.data_ready) begin
               valid_d = 1'b0;
               state_d = S_COLLECT;
               // A bit sampled on the release edge starts the next word.
               if (take_bit) begin
                  data_d    = WIDTH'(qs);
                  bit_cnt_d = CNT_W'(1);
               end else begin
                  bit_cnt_d = '0;
               end
            end else if (bus.sample) begin
               overrun_d = 1'b1;
            end
         end

         default: begin
            state_d   = S_COLLECT;
            valid_d   = 1'b0;
            bit_cnt_d = '0;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_COLLECT;
         q_sync_q  <= '0;
         qb_sync_q <= '0;
         inv_cnt_q <= '0;
         err_q     <= 1'b0;
         overrun_q <= 1'b0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         q_sync_q  <= q_sync_d;
         qb_sync_q <= qb_sync_d;
         inv_cnt_q <= inv_cnt_d;
         err_q     <= err_d;
         overrun_q <= overrun_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end

   assign bus.data_out    = data_q;
   assign bus.data_valid  = valid_q;
   assign bus.bit_cnt     = bit_cnt_q;
   assign bus.err_invalid = err_q;
   assign bus.overrun     = overrun_q;

endmodule
